// File: rtl/zbt_frame_arbiter.sv
// Packs 18-bit pixels two per 36-bit word into a frame buffer and shares one ZBT port between
// those buffered writes and tagged random reads. Commands are registered; read data returns three edges after grant.
module zbt_frame_arbiter #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          FRAME_DIV    = 2,
    parameter logic [18:0] WR_BASE      = 19'd0,
    parameter logic [18:0] FRAME_WORDS  = 19'd153600,
    parameter int          MAX_RD_BURST = 8
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [17:0] pix_data,
    output logic        pix_ready,
    output logic        overflow,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [35:0] rd_data,
    output logic        zbt_cen,
    output logic        zbt_we,
    output logic [18:0] zbt_addr,
    output logic [35:0] zbt_write_data,
    output logic        zbt_frame_enable,
    input  logic [35:0] zbt_read_data
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int BW  = $clog2(MAX_RD_BURST + 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]  BURST_C   = BW'(MAX_RD_BURST);
    localparam logic [FCW-1:0] FDIV_LAST = FCW'(FRAME_DIV - 1);
    localparam logic [18:0]    WR_LAST   = WR_BASE + FRAME_WORDS - 19'd1;

    logic [54:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           frame_en_q, frame_en_d;
    logic           half_q, half_d;
    logic [17:0]    low_q, low_d;
    logic [18:0]    wr_addr_q, wr_addr_d;
    logic           overflow_q, overflow_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic           cen_q, cen_d, we_q, we_d, fe_q;
    logic [18:0]    addr_q, addr_d;
    logic [35:0]    wdata_q, wdata_d;
    logic [2:0]     rd_pipe_q, rd_pipe_d;
    logic           rd_valid_q;
    logic [35:0]    rd_data_q, rd_data_d;
    logic           push, pop, fifo_ne, grant;
    logic [54:0]    fifo_head;

    assign pix_ready        = (count_q < DEPTH_C);
    assign overflow         = overflow_q;
    assign rd_ack           = grant;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign zbt_cen          = cen_q;
    assign zbt_we           = we_q;
    assign zbt_addr         = addr_q;
    assign zbt_write_data   = wdata_q;
    assign zbt_frame_enable = fe_q;
    assign fifo_ne          = (count_q != '0);
    assign fifo_head        = fifo_mem_q[rd_ptr_q];

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        frame_en_d  = frame_en_q;
        half_d      = half_q;
        low_d       = low_q;
        wr_addr_d   = wr_addr_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        if (pix_valid && !pix_ready && frame_en_q) overflow_d = 1'b1;
        if (pix_valid && pix_ready) begin
            if (pix_sof) begin
                // The frame that starts while the counter reads zero is the stored one.
                frame_cnt_d = (frame_cnt_q == FDIV_LAST) ? '0 : frame_cnt_q + 1'b1;
                frame_en_d  = (frame_cnt_q == '0);
                half_d      = (frame_cnt_q == '0);
                low_d       = pix_data;
                wr_addr_d   = WR_BASE;
            end else if (frame_en_q) begin
                if (!half_q) begin
                    low_d  = pix_data;
                    half_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    half_d    = 1'b0;
                    wr_addr_d = (wr_addr_q == WR_LAST) ? WR_BASE : wr_addr_q + 19'd1;
                end
            end
        end
    end

    always_comb begin
        cen_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        burst_d = '0;
        pop     = 1'b0;
        grant   = rd_req && !(fifo_ne && (burst_q == BURST_C));
        if (grant) begin
            cen_d   = 1'b1;
            addr_d  = rd_addr;
            burst_d = fifo_ne ? burst_q + 1'b1 : '0;
        end else if (fifo_ne) begin
            pop     = 1'b1;
            cen_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = fifo_head[54:36];
            wdata_d = fifo_head[35:0];
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        // Grant, command on pins, driver pipeline stage; data is captured on the next edge.
        rd_pipe_d = {rd_pipe_q[1:0], grant};
        rd_data_d = rd_pipe_q[2] ? zbt_read_data : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {wr_addr_q, pix_data, low_q};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            frame_en_q  <= 1'b1;
            half_q      <= 1'b0;
            low_q       <= '0;
            wr_addr_q   <= WR_BASE;
            overflow_q  <= 1'b0;
            burst_q     <= '0;
            cen_q       <= 1'b0;
            we_q        <= 1'b0;
            fe_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            frame_en_q  <= frame_en_d;
            half_q      <= half_d;
            low_q       <= low_d;
            wr_addr_q   <= wr_addr_d;
            overflow_q  <= overflow_d;
            burst_q     <= burst_d;
            cen_q       <= cen_d;
            we_q        <= we_d;
            fe_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_pipe_q[2];
            rd_data_q   <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Directed bench for zbt_frame_arbiter: write packing, read latency, burst limiting, overflow, frame gating, wrap, reset.
module tb_zbt_frame_arbiter;
    logic        clk = 1'b0;
    logic        reset_b;
    logic        pix_valid, pix_sof;
    logic [17:0] pix_data;
    logic        pix_ready, overflow;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_ack, rd_valid;
    logic [35:0] rd_data;
    logic        zbt_cen, zbt_we, zbt_frame_enable;
    logic [18:0] zbt_addr;
    logic [35:0] zbt_write_data;
    logic [35:0] zbt_read_data = '0;
    logic [35:0] mdl_p1 = '0;

    int checks   = 0;
    int failures = 0;
    logic [54:0] exp_wq[$];
    logic [35:0] exp_rq[$];

    always #5 clk = ~clk;

    zbt_frame_arbiter #(.FIFO_DEPTH(4), .FRAME_DIV(2), .WR_BASE(19'd0), .FRAME_WORDS(19'd4), .MAX_RD_BURST(8)) dut (
        .clk(clk), .reset_b(reset_b),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .pix_ready(pix_ready), .overflow(overflow),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .zbt_cen(zbt_cen), .zbt_we(zbt_we), .zbt_addr(zbt_addr),
        .zbt_write_data(zbt_write_data), .zbt_frame_enable(zbt_frame_enable),
        .zbt_read_data(zbt_read_data)
    );

    function automatic logic [35:0] mem_word(input logic [18:0] a);
        return 36'hABCDE0000 | {17'd0, a};
    endfunction

    // Driver model: read data appears two edges after the command is on the pins.
    always @(posedge clk) begin
        mdl_p1        <= (zbt_cen && !zbt_we) ? mem_word(zbt_addr) : 36'h0;
        zbt_read_data <= mdl_p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [17:0] d);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = d;
        tick();
    endtask

    task automatic px_off();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic exp_wr(input logic [18:0] a, input logic [35:0] d);
        exp_wq.push_back({a, d});
    endtask

    always @(negedge clk) begin
        logic [54:0] w;
        logic [35:0] r;
        if (zbt_cen && zbt_we) begin
            chk("wr_expected", 64'(exp_wq.size() != 0), 64'd1);
            if (exp_wq.size() != 0) begin
                w = exp_wq.pop_front();
                chk("wr_addr", 64'(zbt_addr), 64'(w[54:36]));
                chk("wr_data", 64'(zbt_write_data), 64'(w[35:0]));
                chk("wr_frame_en", 64'(zbt_frame_enable), 64'd1);
            end
        end
        if (zbt_cen && !zbt_we) chk("rd_frame_en", 64'(zbt_frame_enable), 64'd0);
        if (rd_valid) begin
            chk("rd_expected", 64'(exp_rq.size() != 0), 64'd1);
            if (exp_rq.size() != 0) begin
                r = exp_rq.pop_front();
                chk("rd_data_mon", 64'(rd_data), 64'(r));
            end
        end
    end

    initial begin
        logic [4:0] vpat;
        reset_b   = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        tick();
        tick();
        chk("rst_pix_ready", 64'(pix_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_cen", 64'(zbt_cen), 64'd0);
        chk("rst_we", 64'(zbt_we), 64'd0);
        chk("rst_addr", 64'(zbt_addr), 64'd0);
        chk("rst_wdata", 64'(zbt_write_data), 64'd0);
        chk("rst_fe", 64'(zbt_frame_enable), 64'd0);
        reset_b = 1'b1;
        tick();

        // Write path
        exp_wr(19'd0, 36'h000080001);
        exp_wr(19'd1, 36'h000100003);
        send(1'b1, 18'h00001);
        send(1'b0, 18'h00002);
        send(1'b0, 18'h00003);
        chk("wp_cen", 64'(zbt_cen), 64'd1);
        chk("wp_we", 64'(zbt_we), 64'd1);
        chk("wp_addr0", 64'(zbt_addr), 64'd0);
        chk("wp_data0", 64'(zbt_write_data), 64'h000080001);
        send(1'b0, 18'h00004);
        chk("wp_idle_cen", 64'(zbt_cen), 64'd0);
        px_off();
        tick();
        chk("wp_addr1", 64'(zbt_addr), 64'd1);
        chk("wp_data1", 64'(zbt_write_data), 64'h000100003);
        tick();
        chk("wp_idle2", 64'(zbt_cen), 64'd0);

        // Single read latency
        rd_req  = 1'b1;
        rd_addr = 19'h00123;
        #1;
        chk("rl_ack", 64'(rd_ack), 64'd1);
        exp_rq.push_back(36'hABCDE0123);
        tick();
        rd_req = 1'b0;
        chk("rl_cmd_cen", 64'(zbt_cen), 64'd1);
        chk("rl_cmd_we", 64'(zbt_we), 64'd0);
        chk("rl_cmd_addr", 64'(zbt_addr), 64'h123);
        chk("rl_v_k0", 64'(rd_valid), 64'd0);
        tick();
        chk("rl_v_k1", 64'(rd_valid), 64'd0);
        tick();
        chk("rl_v_k2", 64'(rd_valid), 64'd0);
        tick();
        chk("rl_v_k3", 64'(rd_valid), 64'd1);
        chk("rl_data_k3", 64'(rd_data), 64'hABCDE0123);
        tick();
        chk("rl_v_k4", 64'(rd_valid), 64'd0);
        chk("rl_data_hold", 64'(rd_data), 64'hABCDE0123);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 19'(i + 1);
            #1;
            chk("b2b_ack", 64'(rd_ack), 64'd1);
            exp_rq.push_back(mem_word(19'(i + 1)));
            tick();
        end
        rd_req = 1'b0;
        vpat   = '0;
        for (int i = 0; i < 5; i++) begin
            vpat = {vpat[3:0], rd_valid};
            if (i < 4) tick();
        end
        chk("b2b_valid_pattern", 64'(vpat), 64'b11110);
        tick();
        chk("b2b_rq_empty", 64'(exp_rq.size()), 64'd0);

        // Burst limit: reads win 8 times, then one write slips in
        exp_wr(19'd2, 36'h000480011);
        exp_wr(19'd3, 36'h000500013);
        for (int i = 0; i < 22; i++) begin
            pix_valid = (i < 4);
            pix_sof   = 1'b0;
            pix_data  = 18'(18'h11 + i);
            rd_req    = 1'b1;
            rd_addr   = 19'd5;
            #1;
            chk("st_ack", 64'(rd_ack), 64'((i != 10) && (i != 19)));
            if ((i != 10) && (i != 19)) exp_rq.push_back(mem_word(19'd5));
            tick();
        end
        rd_req = 1'b0;
        px_off();
        repeat (6) tick();
        chk("st_wq_empty", 64'(exp_wq.size()), 64'd0);
        chk("st_rq_empty", 64'(exp_rq.size()), 64'd0);

        // Overflow under read pressure
        exp_wr(19'd0, 36'h000840020);
        exp_wr(19'd1, 36'h0008C0022);
        exp_wr(19'd2, 36'h000940024);
        exp_wr(19'd3, 36'h0009C0026);
        for (int i = 0; i < 12; i++) begin
            pix_valid = (i <= 10);
            pix_sof   = 1'b0;
            pix_data  = 18'(18'h20 + i);
            rd_req    = (i < 11);
            rd_addr   = 19'd7;
            #1;
            chk("ov_pix_ready", 64'(pix_ready), 64'((i < 8) || (i == 11)));
            chk("ov_overflow", 64'(overflow), 64'(i >= 9));
            if (i < 11) chk("ov_ack", 64'(rd_ack), 64'(i < 10));
            if (i < 10) exp_rq.push_back(mem_word(19'd7));
            tick();
        end
        px_off();
        rd_req = 1'b0;
        repeat (6) tick();
        chk("ov_wq_empty", 64'(exp_wq.size()), 64'd0);
        chk("ov_rq_empty", 64'(exp_rq.size()), 64'd0);
        chk("ov_sticky", 64'(overflow), 64'd1);

        // Second frame is skipped
        send(1'b1, 18'h70);
        for (int i = 1; i < 6; i++) send(1'b0, 18'(18'h70 + i));
        px_off();
        repeat (4) tick();
        chk("fg_no_write_cen", 64'(zbt_cen), 64'd0);
        chk("fg_wq_empty", 64'(exp_wq.size()), 64'd0);

        // Reset while a read is in flight
        rd_req  = 1'b1;
        rd_addr = 19'd9;
        #1;
        chk("rr_ack", 64'(rd_ack), 64'd1);
        tick();
        rd_req = 1'b0;
        tick();
        reset_b = 1'b0;
        #1;
        chk("rr_rd_valid", 64'(rd_valid), 64'd0);
        chk("rr_rd_data", 64'(rd_data), 64'd0);
        chk("rr_cen", 64'(zbt_cen), 64'd0);
        chk("rr_addr", 64'(zbt_addr), 64'd0);
        chk("rr_wdata", 64'(zbt_write_data), 64'd0);
        chk("rr_pix_ready", 64'(pix_ready), 64'd1);
        chk("rr_overflow", 64'(overflow), 64'd0);
        tick();
        tick();
        reset_b = 1'b1;
        repeat (4) tick();
        chk("rr_no_valid", 64'(rd_valid), 64'd0);

        // Address wrap, orphan half discarded at sof, frame decimation
        exp_wr(19'd0, 36'h000C80031);
        exp_wr(19'd1, 36'h000D00033);
        exp_wr(19'd2, 36'h000D80035);
        exp_wr(19'd3, 36'h000E00037);
        exp_wr(19'd0, 36'h000E80039);
        exp_wr(19'd0, 36'h001440050);
        exp_wr(19'd0, 36'h001840060);
        for (int i = 0; i < 10; i++) send(1'b0, 18'(18'h31 + i));
        send(1'b0, 18'h41);
        send(1'b1, 18'h50);
        send(1'b0, 18'h51);
        send(1'b1, 18'h58);
        send(1'b0, 18'h59);
        send(1'b1, 18'h60);
        send(1'b0, 18'h61);
        px_off();
        repeat (4) tick();
        chk("wr_wq_empty", 64'(exp_wq.size()), 64'd0);
        chk("wr_rq_empty", 64'(exp_rq.size()), 64'd0);
        chk("wr_idle", 64'(zbt_cen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
